// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate controller: group FSM state encoding
// and the hold-counter width helper.
package clk_gate_pkg;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_OFF  = OFF,
    S_ON   = ON,
    S_HOLD = HOLD
  } grp_state_e;

  // Bits needed to hold values 0..hold_cyc, never less than one.
  function automatic int hold_cnt_w(input int hold_cyc);
    int w;
    w = $clog2(hold_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cg_grp_fsm.sv
// One register group's OFF/ON/HOLD FSM with its hold-off counter and, when
// ACTIVITY_STATS_EN is defined, its saturating gated-cycle counter.
module cg_grp_fsm
  import clk_gate_pkg::*;
#(
  parameter int HOLD_CYC = 4
`ifdef ACTIVITY_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en_req,
  output logic             open_nxt,
  output logic             grp_active
`ifdef ACTIVITY_STATS_EN
  ,
  input  logic             gate_en,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] gated_cnt
`endif
);

  localparam int             HW        = hold_cnt_w(HOLD_CYC);
  localparam logic [HW-1:0]  HOLD_INIT = (HOLD_CYC > 0) ? HW'(HOLD_CYC - 1) : '0;

  grp_state_e    state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      S_OFF: begin
        if (en_req) state_nxt = S_ON;
      end
      S_ON: begin
        if (!en_req) begin
          // With no hold configured the gate closes straight from ON.
          if (HOLD_CYC == 0) begin
            state_nxt = S_OFF;
          end else begin
            state_nxt    = S_HOLD;
            hold_cnt_nxt = HOLD_INIT;
          end
        end
      end
      S_HOLD: begin
        if (en_req) begin
          state_nxt = S_ON;
        end else if (hold_cnt == '0) begin
          state_nxt = S_OFF;
        end else begin
          hold_cnt_nxt = hold_cnt - HW'(1);
        end
      end
      default: state_nxt = S_OFF;
    endcase
  end

  assign open_nxt = (state_nxt != S_OFF);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_OFF;
      hold_cnt   <= '0;
      grp_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      grp_active <= (state_nxt == S_ON);
    end
  end

`ifdef ACTIVITY_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counts edges on which the registered gate was closed; clear beats increment.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      gated_cnt <= '0;
    end else if (clr_stats) begin
      gated_cnt <= '0;
    end else if (!gate_en && (gated_cnt != CNT_MAX)) begin
      gated_cnt <= gated_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: one hold-off FSM per register group, FORCE_ON
// bypass merged into the registered ICG enables. Optional macro: ACTIVITY_STATS_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_GRP    = 2,
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_GRP-1:0]       EN_REQ,
  input  logic                   FORCE_ON,
  output logic [N_GRP-1:0]       GATE_EN,
  output logic [N_GRP-1:0]       GRP_ACTIVE
`ifdef ACTIVITY_STATS_EN
  ,
  input  logic                   CLR_STATS,
  output logic [N_GRP*CNT_W-1:0] GATED_CNT
`endif
);

  logic [N_GRP-1:0] open_nxt;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    cg_grp_fsm #(
      .HOLD_CYC (HOLD_CYC)
`ifdef ACTIVITY_STATS_EN
      ,
      .CNT_W    (CNT_W)
`endif
    ) u_fsm (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .en_req     (EN_REQ[g]),
      .open_nxt   (open_nxt[g]),
      .grp_active (GRP_ACTIVE[g])
`ifdef ACTIVITY_STATS_EN
      ,
      .gate_en    (GATE_EN[g]),
      .clr_stats  (CLR_STATS),
      .gated_cnt  (GATED_CNT[g*CNT_W +: CNT_W])
`endif
    );
  end

  // FORCE_ON only widens the gate; the FSMs keep tracking the true requests.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      GATE_EN <= '0;
    end else begin
      GATE_EN <= open_nxt | {N_GRP{FORCE_ON}};
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomized self-checking bench for clk_gate_ctrl, HOLD_CYC=4 and HOLD_CYC=0
// instances side by side; covers GATED_CNT when ACTIVITY_STATS_EN is defined.
module tb_clk_gate_ctrl;

  localparam int BIG = 1 << 20;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       FORCE_ON;
  logic [1:0] EN_REQ;
  logic [1:0] gate4, act4, gate0, act0;
`ifdef ACTIVITY_STATS_EN
  logic       CLR_STATS;
  logic [7:0] cnt4, cnt0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: edges elapsed since each group's request was last seen high.
  int         age4 [2];
  int         age0 [2];
  logic [1:0] g4_m, g0_m, a_m;
  int         c4_m [2];
  int         c0_m [2];

  always #5 CLK = ~CLK;

  clk_gate_ctrl #(.N_GRP(2), .HOLD_CYC(4), .CNT_W(4)) u_h4 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN_REQ     (EN_REQ),
    .FORCE_ON   (FORCE_ON),
    .GATE_EN    (gate4),
    .GRP_ACTIVE (act4)
`ifdef ACTIVITY_STATS_EN
    ,
    .CLR_STATS  (CLR_STATS),
    .GATED_CNT  (cnt4)
`endif
  );

  clk_gate_ctrl #(.N_GRP(2), .HOLD_CYC(0), .CNT_W(4)) u_h0 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN_REQ     (EN_REQ),
    .FORCE_ON   (FORCE_ON),
    .GATE_EN    (gate0),
    .GRP_ACTIVE (act0)
`ifdef ACTIVITY_STATS_EN
    ,
    .CLR_STATS  (CLR_STATS),
    .GATED_CNT  (cnt0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference update for one clock edge, from the inputs present at that edge.
  task automatic model_edge(input logic clr);
    for (int g = 0; g < 2; g++) begin
      if (!RST_N) begin
        age4[g] = BIG; age0[g] = BIG; c4_m[g] = 0; c0_m[g] = 0;
        g4_m[g] = 1'b0; g0_m[g] = 1'b0; a_m[g] = 1'b0;
      end else begin
        if (clr) begin
          c4_m[g] = 0; c0_m[g] = 0;
        end else begin
          if (!g4_m[g] && c4_m[g] < 15) c4_m[g]++;
          if (!g0_m[g] && c0_m[g] < 15) c0_m[g]++;
        end
        age4[g] = EN_REQ[g] ? 0 : ((age4[g] < BIG) ? age4[g] + 1 : BIG);
        age0[g] = EN_REQ[g] ? 0 : ((age0[g] < BIG) ? age0[g] + 1 : BIG);
        g4_m[g] = (age4[g] <= 4) || FORCE_ON;
        g0_m[g] = (age0[g] <= 0) || FORCE_ON;
        a_m[g]  = EN_REQ[g];
      end
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] req, input logic frc, input logic clr);
    RST_N    = rst;
    EN_REQ   = req;
    FORCE_ON = frc;
`ifdef ACTIVITY_STATS_EN
    CLR_STATS = clr;
`endif
    @(posedge CLK);
    model_edge(clr);
    #1;
    chk("gate_h4", {30'd0, gate4}, {30'd0, g4_m});
    chk("act_h4",  {30'd0, act4},  {30'd0, a_m});
    chk("gate_h0", {30'd0, gate0}, {30'd0, g0_m});
    chk("act_h0",  {30'd0, act0},  {30'd0, a_m});
`ifdef ACTIVITY_STATS_EN
    chk("cnt_h4_g0", {28'd0, cnt4[3:0]}, c4_m[0]);
    chk("cnt_h4_g1", {28'd0, cnt4[7:4]}, c4_m[1]);
    chk("cnt_h0_g0", {28'd0, cnt0[3:0]}, c0_m[0]);
    chk("cnt_h0_g1", {28'd0, cnt0[7:4]}, c0_m[1]);
`endif
  endtask

  initial begin
    logic [1:0] req;
    logic       rst, frc, clr;

    for (int g = 0; g < 2; g++) begin
      age4[g] = BIG; age0[g] = BIG; c4_m[g] = 0; c0_m[g] = 0;
    end
    g4_m = '0; g0_m = '0; a_m = '0;

    // Reset holds everything closed even with both requests high.
    repeat (2) begin
      step(1'b0, 2'b11, 1'b0, 1'b0);
      chk("rst_gate", {30'd0, gate4 | gate0}, 32'd0);
      chk("rst_act",  {30'd0, act4 | act0},   32'd0);
    end

    // Long idle: gated counters saturate, then one clear edge zeroes them.
    repeat (20) step(1'b1, 2'b00, 1'b0, 1'b0);
`ifdef ACTIVITY_STATS_EN
    chk("cnt_sat", {24'd0, cnt4}, 32'hff);
    step(1'b1, 2'b00, 1'b0, 1'b1);
    chk("cnt_clr", {24'd0, cnt4}, 32'd0);
`endif

    // Two-cycle request on group 0, then hold-off tail of four edges.
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("gate_rise", {30'd0, gate4}, 32'd1);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      chk("hold_tail", {30'd0, gate4}, (i <= 4) ? 32'd1 : 32'd0);
    end

    // Re-request during HOLD keeps the gate open with no gap.
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("hold_act", {30'd0, act4}, 32'd0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("rereq_gate", {30'd0, gate4}, 32'd1);
    chk("rereq_act",  {30'd0, act4},  32'd1);
    repeat (6) step(1'b1, 2'b00, 1'b0, 1'b0);

    // FORCE_ON opens gates only while asserted.
    repeat (4) begin
      step(1'b1, 2'b00, 1'b1, 1'b0);
      chk("force_gate", {30'd0, gate4}, 32'd3);
    end
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("force_rel", {30'd0, gate4}, 32'd0);

    // Single-cycle pulse with no hold configured.
    step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("pulse_h0", {30'd0, gate0}, 32'd2);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("pulse_h0_off", {30'd0, gate0}, 32'd0);

    // Bursty random traffic with occasional force, clear and reset.
    req = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int g = 0; g < 2; g++)
        if ($urandom_range(3) == 0) req[g] = ~req[g];
      frc = ($urandom_range(15) == 0);
      clr = ($urandom_range(31) == 0);
      rst = ($urandom_range(63) != 0);
      step(rst, req, frc, clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
